// File: rtl/sid_audio_decim.sv
// SID audio decimator: one-pole low-pass on the ~1 MHz SID mixer stream, phase-accumulator
// rate conversion to PHASE_INC/PHASE_MOD, and a 4-entry first-word-fall-through output FIFO.
module sid_audio_decim #(
  parameter int PHASE_INC   = 48000,
  parameter int PHASE_MOD   = 985248,
  parameter int ALPHA_SHIFT = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ce_1m,
  input  logic signed [17:0] audio_in,
  output logic signed [15:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2:0]         fifo_level,
  output logic               overflow
);

  localparam logic [20:0] INC_W = 21'(PHASE_INC);
  localparam logic [20:0] MOD_W = 21'(PHASE_MOD);

  // y is Q18.4; the input is lifted to the same format before the difference.
  function automatic logic signed [21:0] lp_step(input logic signed [21:0] y,
                                                 input logic signed [17:0] a);
    logic signed [22:0] x;
    logic signed [22:0] d;
    logic signed [22:0] dsh;
    x   = {a[17], a, 4'b0000};
    d   = x - {y[21], y};
    dsh = d >>> ALPHA_SHIFT;
    return y + dsh[21:0];
  endfunction

  function automatic logic signed [15:0] trunc_sample(input logic signed [21:0] y);
    return y[21:6];
  endfunction

  logic signed [21:0] y_q, y_d;
  logic [19:0]        phase_q, phase_d;
  logic               tick_q, tick_d;
  logic [1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]         level_q, level_d;
  logic               overflow_q, overflow_d;
  logic signed [15:0] hold_q, hold_d;
  logic signed [15:0] mem_q [4];
  logic signed [15:0] mem_d [4];

  logic [20:0] phase_sum;
  logic        wrap, full, pop, wr_en;

  always_comb begin
    phase_sum = {1'b0, phase_q} + INC_W;
    wrap      = (phase_sum >= MOD_W);

    y_d     = y_q;
    phase_d = phase_q;
    tick_d  = 1'b0;
    if (ce_1m) begin
      y_d     = lp_step(y_q, audio_in);
      phase_d = wrap ? 20'(phase_sum - MOD_W) : phase_sum[19:0];
      tick_d  = wrap;
    end

    // Stage boundary: tick_q marks the cycle that pushes the filtered sample.
    full  = (level_q == 3'd4);
    pop   = (level_q != 3'd0) && out_ready;
    wr_en = tick_q && (!full || pop);

    overflow_d = overflow_q | (tick_q && full && !pop);
    wr_ptr_d   = wr_en ? wr_ptr_q + 2'd1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 2'd1 : rd_ptr_q;
    level_d    = level_q;
    if (wr_en && !pop)      level_d = level_q + 3'd1;
    else if (!wr_en && pop) level_d = level_q - 3'd1;

    mem_d = mem_q;
    if (wr_en && !reset) mem_d[wr_ptr_q] = trunc_sample(y_q);

    // The held word keeps out_data stable once the FIFO drains.
    hold_d = (level_q != 3'd0) ? mem_q[rd_ptr_q] : hold_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      y_q        <= '0;
      phase_q    <= '0;
      tick_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      hold_q     <= '0;
    end else begin
      y_q        <= y_d;
      phase_q    <= phase_d;
      tick_q     <= tick_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      hold_q     <= hold_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign out_valid  = (level_q != 3'd0);
  assign out_data   = out_valid ? mem_q[rd_ptr_q] : hold_q;
  assign fifo_level = level_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_sid_audio_decim.sv
// Bench for sid_audio_decim: two instances (MOD=4 and MOD=2) checked every cycle against a
// sample-list model, plus directed DC, rate, reset and overflow scenarios with literal values.
module tb_sid_audio_decim;

  localparam int A = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        ce_a, rdy_a, ce_b, rdy_b;
  logic [17:0] aud_a, aud_b;
  logic [15:0] dout_a, dout_b;
  logic        vld_a, vld_b, ovf_a, ovf_b;
  logic [2:0]  lvl_a, lvl_b;

  sid_audio_decim #(.PHASE_INC(1), .PHASE_MOD(4), .ALPHA_SHIFT(A)) dut_a (
    .clk(clk), .reset(reset), .ce_1m(ce_a), .audio_in(aud_a), .out_data(dout_a),
    .out_valid(vld_a), .out_ready(rdy_a), .fifo_level(lvl_a), .overflow(ovf_a));

  sid_audio_decim #(.PHASE_INC(1), .PHASE_MOD(2), .ALPHA_SHIFT(A)) dut_b (
    .clk(clk), .reset(reset), .ce_1m(ce_b), .audio_in(aud_b), .out_data(dout_b),
    .out_valid(vld_b), .out_ready(rdy_b), .fifo_level(lvl_b), .overflow(ovf_b));

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Model: filter value, phase count, pending-push flag, and the list of accepted samples.
  int  my [2];
  int  mph [2];
  bit  mtick [2];
  bit  movf [2];
  int  npush [2];
  int  npop [2];
  int  hist [2][1024];
  int  minc [2] = '{1, 1};
  int  mmod [2] = '{4, 2};
  int  cyc = 0;
  bit  chk_en = 1'b0;

  function automatic int smp(input int y);
    return (y >>> 6) & 32'hFFFF;
  endfunction

  task automatic model_step(input int i, input logic ce, input logic signed [17:0] aud,
                            input logic rdy);
    int lv;
    int x;
    bit pop;
    lv  = npush[i] - npop[i];
    pop = (lv > 0) && rdy;
    if (mtick[i]) begin
      if (lv == 4 && !pop) movf[i] = 1'b1;
      else if (npush[i] < 1024) begin
        hist[i][npush[i]] = smp(my[i]);
        npush[i]++;
      end
    end
    if (pop) npop[i]++;
    if (ce) begin
      x = aud * 16;
      my[i] = my[i] + ((x - my[i]) >>> A);
      mph[i] = mph[i] + minc[i];
      if (mph[i] >= mmod[i]) begin
        mph[i] = mph[i] - mmod[i];
        mtick[i] = 1'b1;
      end else mtick[i] = 1'b0;
    end else mtick[i] = 1'b0;
  endtask

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        my[i] = 0; mph[i] = 0; mtick[i] = 1'b0; movf[i] = 1'b0; npush[i] = 0; npop[i] = 0;
      end
    end else begin
      model_step(0, ce_a, aud_a, rdy_a);
      model_step(1, ce_b, aud_b, rdy_b);
    end
  end

  task automatic cmp(input int i, input logic v, input logic [2:0] l, input logic o,
                     input logic [15:0] d);
    int lv;
    lv = npush[i] - npop[i];
    check($sformatf("dut%0d.out_valid", i), v, (lv > 0));
    check($sformatf("dut%0d.fifo_level", i), l, lv);
    check($sformatf("dut%0d.overflow", i), o, movf[i]);
    if (lv > 0) check($sformatf("dut%0d.out_data", i), d, hist[i][npop[i]]);
  endtask

  bit          rate_arm = 1'b0;
  bit          prev_vld_a = 1'b0;
  int          t_rise = -1;
  int          t_ce4 = 0;
  int          pops_a = 0;
  logic [15:0] last_pop_a = '0;

  always @(negedge clk) begin
    if (chk_en) begin
      cmp(0, vld_a, lvl_a, ovf_a, dout_a);
      cmp(1, vld_b, lvl_b, ovf_b, dout_b);
    end
    if (vld_a && rdy_a) last_pop_a = dout_a;
    if (rate_arm) begin
      if (vld_a && !prev_vld_a && t_rise < 0) t_rise = cyc;
      if (vld_a && rdy_a) pops_a++;
    end
    prev_vld_a = vld_a;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic pulse_b();
    ce_b = 1'b1;
    step();
    ce_b = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b1;
    ce_a = 1'b0; aud_a = '0; rdy_a = 1'b0;
    ce_b = 1'b0; aud_b = '0; rdy_b = 1'b0;

    // Reset held for two clocks while inputs toggle randomly.
    for (int k = 0; k < 2; k++) begin
      ce_a = 1'($urandom); aud_a = 18'($urandom); rdy_a = 1'($urandom);
      ce_b = 1'($urandom); aud_b = 18'($urandom); rdy_b = 1'($urandom);
      step();
      chk_en = 1'b1;
    end
    check("rst_a.out_valid", vld_a, 0);
    check("rst_a.fifo_level", lvl_a, 0);
    check("rst_a.overflow", ovf_a, 0);
    check("rst_a.out_data", dout_a, 16'h0000);
    check("rst_b.out_valid", vld_b, 0);
    check("rst_b.fifo_level", lvl_b, 0);
    check("rst_b.overflow", ovf_b, 0);
    check("rst_b.out_data", dout_b, 16'h0000);
    ce_a = 1'b0; aud_a = '0; rdy_a = 1'b0;
    ce_b = 1'b0; aud_b = '0; rdy_b = 1'b0;
    reset = 1'b0;
    step();

    // Positive full-scale DC settles to 0x7FFF.
    rdy_a = 1'b1;
    ce_a = 1'b1; aud_a = 18'h1FFFF;
    repeat (400) step();
    ce_a = 1'b0;
    repeat (6) step();
    check("dc_pos.popped", last_pop_a, 16'h7FFF);
    check("dc_pos.model", hist[0][npush[0]-1], 16'h7FFF);

    // Negative full-scale DC settles to exactly 0x8000.
    do_reset();
    ce_a = 1'b1; aud_a = 18'h20000;
    repeat (400) step();
    ce_a = 1'b0;
    repeat (6) step();
    check("dc_neg.popped", last_pop_a, 16'h8000);
    check("dc_neg.model", hist[0][npush[0]-1], 16'h8000);

    // Rate: ce every third clock, one push per four strobes.
    do_reset();
    rate_arm = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      ce_a = 1'b1; aud_a = 18'(k * 100);
      if (k == 4) t_ce4 = cyc;
      step();
      ce_a = 1'b0;
      step();
      step();
    end
    repeat (5) step();
    rate_arm = 1'b0;
    check("rate.first_valid_delay", t_rise - t_ce4, 2);
    check("rate.push_count", pops_a, 10);

    // Reset lands in the tick cycle: the pending push is discarded.
    rdy_a = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ce_a = 1'b1; aud_a = 18'h00400;
      step();
    end
    ce_a = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst.fifo_level", lvl_a, 0);
    check("midrst.out_valid", vld_a, 0);
    step();
    check("midrst.next_level", lvl_a, 0);
    check("midrst.next_valid", vld_a, 0);

    // Overflow: FIFO fills after 8 strobes, 10th strobe's sample is dropped.
    do_reset();
    rdy_b = 1'b0; aud_b = 18'h00100;
    repeat (8) pulse_b();
    step();
    check("ovf.level_full", lvl_b, 4);
    check("ovf.flag_clear", ovf_b, 0);
    repeat (2) pulse_b();
    step();
    check("ovf.flag_set", ovf_b, 1);
    check("ovf.level_held", lvl_b, 4);
    check("ovf.head_first", dout_b, 16'h000F);

    // Full FIFO with push and pop together: accepted, head moves to sample 2.
    do_reset();
    repeat (9) pulse_b();
    ce_b = 1'b1;
    step();
    ce_b = 1'b0;
    rdy_b = 1'b1;
    step();
    rdy_b = 1'b0;
    step();
    check("pushpop.level", lvl_b, 4);
    check("pushpop.overflow", ovf_b, 0);
    check("pushpop.head_second", dout_b, 16'h001A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sid_audio_decim.md
SID_AUDIO_DECIM -- requirements
Module: sid_audio_decim

Interface
REQ-001 Parameter PHASE_INC, default 48000, output sample rate numerator; constraint 0 < PHASE_INC < PHASE_MOD.
REQ-002 Parameter PHASE_MOD, default 985248, input sample rate, i.e. SID clock in Hz.
REQ-003 Parameter ALPHA_SHIFT, default 3, low-pass coefficient 2^-ALPHA_SHIFT; range 1..4.
REQ-004 The clock SHALL be clk, and the reset SHALL be reset: synchronous, active-high.
REQ-005 clk  input  1  system clock, rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 ce_1m  input  1  one-clk strobe; audio_in is valid in this cycle; back-to-back strobes allowed.
REQ-008 audio_in  input  18  signed two's-complement SID mixer output.
REQ-009 out_data  output  16  signed sample at FIFO head.
REQ-010 out_valid  output  1  FIFO non-empty.
REQ-011 out_ready  input  1  consumer accepts out_data this cycle.
REQ-012 fifo_level  output  3  FIFO occupancy, 0..4.
REQ-013 overflow  output  1  sticky flag; a sample was dropped.

Function
REQ-014 Filter state y SHALL be 22-bit signed: 18 integer bits plus 4 fraction bits.
REQ-015 On ce_1m, the block SHALL form x = sign-extended {audio_in, 4'b0} and d = x - y (23-bit), then update y <= y + (d >>> ALPHA_SHIFT) (arithmetic shift).
REQ-016 The phase register SHALL be 20-bit; on ce_1m, phase <= phase + PHASE_INC, or phase + PHASE_INC - PHASE_MOD if that sum >= PHASE_MOD.
REQ-017 The wrap in REQ-016 SHALL set the registered tick in the following cycle; with no wrap, tick = 0.
REQ-018 When tick = 1, the push sample SHALL be y[21:6] (truncation, no rounding); y is not updated between the tick edge and the push, so no saturation is needed.
REQ-019 Latency SHALL be: ce_1m in cycle T -> tick in T+1 -> FIFO write at the end of T+1 -> out_valid = 1 in T+2 if the FIFO was empty.
REQ-020 The FIFO SHALL be 4 entries, first-word-fall-through: out_data = head entry; out_valid = (fifo_level != 0).
REQ-021 A pop SHALL occur when out_valid && out_ready; out_ready is ignored when empty.
REQ-022 Push when not full SHALL be accepted; push plus pop in the same cycle leaves fifo_level unchanged.
REQ-023 Push when full with no pop SHALL drop the new sample, set overflow = 1, and leave contents and head unchanged.
REQ-024 Push when full with a simultaneous pop SHALL be accepted, with no overflow.
REQ-025 overflow SHALL clear only on reset.
REQ-026 When empty, out_data SHALL hold its last value; it is don't-care while out_valid = 0, and 0 after reset.
REQ-027 Pointers SHALL be 2-bit and wrap modulo 4.
REQ-028 With ce_1m = 0, y, phase and tick SHALL hold; the FIFO may still pop.

Reset
REQ-029 When reset = 1 at a clk edge, the block SHALL set y = 0, phase = 0, tick = 0, pointers = 0, fifo_level = 0, out_valid = 0, out_data = 0 and overflow = 0.
REQ-030 Reset SHALL take priority over ce_1m, push and pop in the same cycle.
REQ-031 On reset mid-operation, any pending tick SHALL be discarded and no push SHALL occur in the cycle after reset.

Verification
REQ-032 Reset scenario: assert reset for 2 clk with random inputs -> out_valid = 0, fifo_level = 0, overflow = 0, out_data = 0x0000.
REQ-033 DC positive (INC = 1, MOD = 4, out_ready = 1): audio_in = 0x1FFFF for 400 ce_1m -> final popped samples = 0x7FFF.
REQ-034 DC negative, same setup: audio_in = 0x20000 -> final popped samples = 0x8000 exactly.
REQ-035 Rate, same setup, ce_1m every 3rd clk: the first push follows the 4th ce_1m, and out_valid rises 2 clk after that ce_1m; over 40 ce_1m there SHALL be exactly 10 pushes.
REQ-036 Overflow (INC = 1, MOD = 2, out_ready = 0): after 8 ce_1m -> fifo_level = 4, overflow = 0; on the 10th ce_1m -> overflow = 1, level stays 4, head = first sample.
REQ-037 Full with simultaneous push/pop: drive out_ready = 1 for exactly the push cycle -> level stays 4, overflow stays 0, head advances to sample 2.
